// File: rtl/alu_pkg.sv
// Shared definitions for the alu datapath and its scheduler: opcodes, data width, FSM states.
package alu_pkg;

    localparam int unsigned ALU_W = 4;

    localparam logic [2:0] OC_ADD = 3'b000;
    localparam logic [2:0] OC_SUB = 3'b001;
    localparam logic [2:0] OC_MUL = 3'b010;
    localparam logic [2:0] OC_DIV = 3'b011;
    localparam logic [2:0] OC_NOT = 3'b100;
    localparam logic [2:0] OC_XOR = 3'b101;
    localparam logic [2:0] OC_OR  = 3'b110;
    localparam logic [2:0] OC_AND = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between two operand producers, one result consumer and alu_sched.
interface alu_sched_if #(
    parameter int unsigned CNT_W = 8
);
    import alu_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_oc;
    logic [ALU_W-1:0] req0_a;
    logic [ALU_W-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_oc;
    logic [ALU_W-1:0] req1_a;
    logic [ALU_W-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [ALU_W-1:0] rsp_f;
    logic             rsp_id;
    logic             rsp_err;

    logic             busy;
    logic [CNT_W-1:0] op_cnt;

    modport master (
        output req0_valid, req0_oc, req0_a, req0_b,
        output req1_valid, req1_oc, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_f, rsp_id, rsp_err, busy, op_cnt
    );

    modport slave (
        input  req0_valid, req0_oc, req0_a, req0_b,
        input  req1_valid, req1_oc, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_f, rsp_id, rsp_err, busy, op_cnt
    );

endinterface

// File: rtl/alu.sv
// Combinational 4-bit ALU; arithmetic results wrap modulo 16.
module alu
    import alu_pkg::*;
(
    input  logic [2:0]       oc,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] f
);

    always_comb begin
        f = '0;
        unique case (oc)
            OC_ADD: f = a + b;
            OC_SUB: f = a - b;
            OC_MUL: f = a * b;
            // Divide-by-zero yields all ones here; the scheduler masks it anyway.
            OC_DIV: f = (b == '0) ? '1 : a / b;
            OC_NOT: f = ~a;
            OC_XOR: f = a ^ b;
            OC_OR:  f = a | b;
            OC_AND: f = a & b;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one alu between two requesters, with a valid/ready response.
module alu_sched #(
    parameter int unsigned CNT_W = 8
) (
    input logic       clk,
    input logic       rst_n,
    alu_sched_if.slave bus
);
    import alu_pkg::*;

    state_e           state_q, state_d;
    logic             last_q;
    logic             id_q;
    logic [2:0]       oc_q;
    logic [ALU_W-1:0] a_q, b_q;
    logic [ALU_W-1:0] f_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             grant0, grant1;
    logic             acc0, acc1, accept, hs;
    logic             div0;
    logic [ALU_W-1:0] alu_f;

    // On a tie the requester not served last wins; last_q=1 favours requester 0.
    assign grant0 = bus.req0_valid && (!bus.req1_valid || last_q);
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);

    assign bus.req0_ready = (state_q == ST_IDLE) && grant0;
    assign bus.req1_ready = (state_q == ST_IDLE) && grant1;

    assign acc0   = bus.req0_valid && bus.req0_ready;
    assign acc1   = bus.req1_valid && bus.req1_ready;
    assign accept = acc0 || acc1;
    assign hs     = (state_q == ST_RESP) && bus.rsp_ready;
    assign div0   = (oc_q == OC_DIV) && (b_q == '0);

    alu u_alu (
        .oc (oc_q),
        .a  (a_q),
        .b  (b_q),
        .f  (alu_f)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            oc_q    <= OC_ADD;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q <= acc1;
                id_q   <= acc1;
                oc_q   <= acc1 ? bus.req1_oc : bus.req0_oc;
                a_q    <= acc1 ? bus.req1_a  : bus.req0_a;
                b_q    <= acc1 ? bus.req1_b  : bus.req0_b;
            end
            if (state_q == ST_EXEC) begin
                f_q   <= div0 ? '0 : alu_f;
                err_q <= div0;
            end
            if (hs) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_f     = f_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.op_cnt    = cnt_q;

endmodule
